// File: rtl/console_sched.sv
// Acquisition sequencer: per-run configure handshake, tick-driven conversion,
// then a send/read handshake pair per enabled channel with timeout tracking.
module console_sched #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned TW       = 12,
  parameter int unsigned TOUT     = 1000,
  parameter int unsigned DW       = 24,
  parameter int unsigned TICK_DIV = 999
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [3:0]     fsamp,
  input  logic [NCH-1:0] chan_en,
  output logic           fs_conf,
  input  logic           fd_conf,
  output logic           fs_conv,
  input  logic           fd_conv,
  output logic [NCH-1:0] fs_send,
  input  logic [NCH-1:0] fd_send,
  output logic [NCH-1:0] fs_read,
  input  logic [NCH-1:0] fd_read,
  output logic           tick,
  output logic           busy,
  output logic [NCH-1:0] ch_err,
  output logic [7:0]     ovr_cnt,
  output logic [15:0]    frame_cnt
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StConf = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StConv = 3'd3;
  localparam logic [2:0] StSend = 3'd4;
  localparam logic [2:0] StRead = 3'd5;

  logic [2:0]     state_q, state_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [2:0]     fsamp_q, fsamp_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [TW-1:0]  tout_q, tout_d;
  logic [DW-1:0]  tcnt_q, tcnt_d;

  logic           fs_conf_d, fs_conv_d, tick_d;
  logic [NCH-1:0] fs_send_d, fs_read_d, ch_err_d;
  logic [7:0]     ovr_d;
  logic [15:0]    frame_d;

  logic [CW:0]    first_ch, next_ch;
  logic           fd_s, fd_r, tmo, tick_hit, cnt_hold;
  logic [DW-1:0]  period;

  logic unused_fsamp3;
  assign unused_fsamp3 = fsamp[3];

  // {found, index} of the lowest enabled channel at or above start
  function automatic logic [CW:0] find_ch(input logic [NCH-1:0] mask, input logic [CW:0] start);
    logic [CW:0] res;
    res = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start))) res = {1'b1, CW'(i)};
    end
    return res;
  endfunction

  assign busy = (state_q != StIdle) && (state_q != StWait);

  always_comb begin
    period   = DW'(TICK_DIV + 1) << fsamp_q;
    tick_hit = (tcnt_q == period - DW'(1));
    cnt_hold = (state_q == StIdle) || (state_q == StConf);
    tcnt_d   = (cnt_hold || tick_hit) ? '0 : tcnt_q + DW'(1);
    tick_d   = !cnt_hold && tick_hit;
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    fsamp_d  = fsamp_q;
    mask_d   = mask_q;
    ch_err_d = ch_err;
    ovr_d    = ovr_cnt;
    frame_d  = frame_cnt;
    first_ch = find_ch(mask_q, '0);
    next_ch  = find_ch(mask_q, {1'b0, ch_q} + {{CW{1'b0}}, 1'b1});
    fd_s     = fd_send[ch_q];
    fd_r     = fd_read[ch_q];
    tmo      = (tout_q == TW'(TOUT - 1));

    // A tick that lands mid-frame is dropped and only counted
    if (tick && ((state_q == StConv) || (state_q == StSend) || (state_q == StRead)) &&
        (ovr_cnt != 8'hFF)) begin
      ovr_d = ovr_cnt + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (run) begin
          state_d  = StConf;
          fsamp_d  = fsamp[2:0];
          mask_d   = chan_en;
          ch_err_d = '0;
          ovr_d    = '0;
          frame_d  = '0;
        end
      end
      StConf: if (fd_conf) state_d = StWait;
      StWait: begin
        if (!run)      state_d = StIdle;
        else if (tick) state_d = StConv;
      end
      StConv: begin
        if (fd_conv) begin
          if (first_ch[CW]) begin
            state_d = StSend;
            ch_d    = first_ch[CW-1:0];
          end else begin
            state_d = StWait;
            frame_d = frame_cnt + 16'd1;
          end
        end
      end
      StSend: begin
        if (fd_s || tmo) begin
          if (!fd_s) ch_err_d[ch_q] = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        if (fd_r || tmo) begin
          if (!fd_r) ch_err_d[ch_q] = 1'b1;
          if (next_ch[CW]) begin
            state_d = StSend;
            ch_d    = next_ch[CW-1:0];
          end else begin
            state_d = StWait;
            frame_d = frame_cnt + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Every handshake completion changes state, so this clears on SEND/READ entry
    tout_d    = (state_d != state_q) ? '0 : tout_q + TW'(1);
    fs_conf_d = (state_d == StConf);
    fs_conv_d = (state_d == StConv);
    fs_send_d = (state_d == StSend) ? (NCH'(1) << ch_d) : '0;
    fs_read_d = (state_d == StRead) ? (NCH'(1) << ch_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      fsamp_q   <= '0;
      mask_q    <= '0;
      tout_q    <= '0;
      tcnt_q    <= '0;
      fs_conf   <= 1'b0;
      fs_conv   <= 1'b0;
      fs_send   <= '0;
      fs_read   <= '0;
      tick      <= 1'b0;
      ch_err    <= '0;
      ovr_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      fsamp_q   <= fsamp_d;
      mask_q    <= mask_d;
      tout_q    <= tout_d;
      tcnt_q    <= tcnt_d;
      fs_conf   <= fs_conf_d;
      fs_conv   <= fs_conv_d;
      fs_send   <= fs_send_d;
      fs_read   <= fs_read_d;
      tick      <= tick_d;
      ch_err    <= ch_err_d;
      ovr_cnt   <= ovr_d;
      frame_cnt <= frame_d;
    end
  end

endmodule
